// File: rtl/plugboard.sv
// Enigma plugboard: runtime-loaded involutive letter swap table (up to 13 pairs).
// Latency 2 cycles from valid to done; no backpressure, busy marks LOOKUP/DONE where requests are dropped.
module plugboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       pair_valid,
  input  logic [7:0] pair_a,
  input  logic [7:0] pair_b,
  input  logic       valid,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       done,
  output logic       busy,
  output logic       char_err,
  output logic       cfg_err,
  output logic [3:0] pair_cnt
);

  typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

  state_t     state, state_next;
  logic [4:0] tbl [26];
  logic [7:0] ch;
  logic       err_q;

  logic       idle;
  logic       a_ok, b_ok, ch_ok;
  logic [4:0] ia, ib, ic;
  logic       pair_ok, take_char, take_pair, do_clear, reject_pair;
  logic [7:0] res;

  // 'A'..'Z' carry their 1-based alphabet position in the low five bits
  assign idle  = (state == IDLE);
  assign a_ok  = (pair_a >= 8'd65) && (pair_a <= 8'd90);
  assign b_ok  = (pair_b >= 8'd65) && (pair_b <= 8'd90);
  assign ch_ok = (ch >= 8'd65) && (ch <= 8'd90);
  assign ia    = a_ok  ? (pair_a[4:0] - 5'd1) : 5'd0;
  assign ib    = b_ok  ? (pair_b[4:0] - 5'd1) : 5'd0;
  assign ic    = ch_ok ? (ch[4:0] - 5'd1)     : 5'd0;

  assign pair_ok = a_ok && b_ok && (pair_a != pair_b) &&
                   (tbl[ia] == ia) && (tbl[ib] == ib) && (pair_cnt < 4'd13);

  assign do_clear    = idle && clear;
  assign take_char   = idle && valid && !clear;
  assign take_pair   = idle && pair_valid && !clear && !valid && pair_ok;
  assign reject_pair = pair_valid && !take_pair;

  assign res = ch_ok ? (8'd65 + {3'b000, tbl[ic]}) : ch;

  assign busy     = !idle;
  assign done     = (state == DONE);
  assign char_err = done && err_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_char) state_next = LOOKUP;
      LOOKUP:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ch       <= 8'd0;
      dout     <= 8'd0;
      err_q    <= 1'b0;
      cfg_err  <= 1'b0;
      pair_cnt <= 4'd0;
      for (int i = 0; i < 26; i++) tbl[i] <= 5'(i);
    end else begin
      state   <= state_next;
      cfg_err <= reject_pair;
      if (take_char) ch <= din;
      if (state == LOOKUP) begin
        dout  <= res;
        err_q <= !ch_ok;
      end
      if (do_clear) begin
        pair_cnt <= 4'd0;
        for (int i = 0; i < 26; i++) tbl[i] <= 5'(i);
      end else if (take_pair) begin
        tbl[ia]  <= ib;
        tbl[ib]  <= ia;
        pair_cnt <= pair_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_plugboard.sv
// Directed bench for plugboard: lookup latency, pair loading, rejections, clear and mid-flight reset.
module tb_plugboard;

  logic       clk = 1'b0;
  logic       reset, clear, pair_valid, valid;
  logic [7:0] pair_a, pair_b, din;
  logic [7:0] dout;
  logic       done, busy, char_err, cfg_err;
  logic [3:0] pair_cnt;

  int total = 0;
  int bad   = 0;

  plugboard dut (
    .clk(clk), .reset(reset), .clear(clear), .pair_valid(pair_valid),
    .pair_a(pair_a), .pair_b(pair_b), .valid(valid), .din(din),
    .dout(dout), .done(done), .busy(busy), .char_err(char_err),
    .cfg_err(cfg_err), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: pushes one character and reports what came back and when.
  task automatic run_char(input logic [7:0] c, output logic [7:0] d, output logic e, output int lat);
    valid = 1'b1; din = c;
    tick();
    valid = 1'b0;
    lat = 1;
    while (!done && lat < 6) begin
      tick();
      lat++;
    end
    d = dout; e = char_err;
    tick();
  endtask

  task automatic add_pair(input logic [7:0] a, input logic [7:0] b, output logic err);
    pair_valid = 1'b1; pair_a = a; pair_b = b;
    tick();
    pair_valid = 1'b0;
    err = cfg_err;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h want=00", dout); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (char_err !== 1'b0) begin bad++; $display("FAIL rst_char_err got=%b want=0", char_err); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err got=%b want=0", cfg_err); end
    total++; if (pair_cnt !== 4'd0) begin bad++; $display("FAIL rst_pair_cnt got=%0d want=0", pair_cnt); end
  endtask

  task automatic test_identity();
    valid = 1'b1; din = 8'h51;
    tick();
    valid = 1'b0;
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL id_k1 busy,done got=%b want=10", {busy, done}); end
    tick();
    total++; if ({busy, done} !== 2'b11) begin bad++; $display("FAIL id_k2 busy,done got=%b want=11", {busy, done}); end
    total++; if (dout !== 8'h51) begin bad++; $display("FAIL id_dout got=%h want=51", dout); end
    total++; if (char_err !== 1'b0) begin bad++; $display("FAIL id_char_err got=%b want=0", char_err); end
    tick();
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL id_k3 busy,done got=%b want=00", {busy, done}); end
  endtask

  task automatic test_pair_az();
    logic [7:0] d; logic e, err; int lat;
    add_pair(8'h41, 8'h5A, err);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL az_cfg_err got=%b want=0", err); end
    total++; if (pair_cnt !== 4'd1) begin bad++; $display("FAIL az_cnt got=%0d want=1", pair_cnt); end
    run_char(8'h41, d, e, lat);
    total++; if (d !== 8'h5A || lat !== 2) begin bad++; $display("FAIL az_A got=%h lat=%0d want=5a lat=2", d, lat); end
    run_char(8'h5A, d, e, lat);
    total++; if (d !== 8'h41) begin bad++; $display("FAIL az_Z got=%h want=41", d); end
    run_char(8'h4D, d, e, lat);
    total++; if (d !== 8'h4D || e !== 1'b0) begin bad++; $display("FAIL az_M got=%h err=%b want=4d err=0", d, e); end
  endtask

  task automatic test_reject();
    logic [7:0] d; logic e, err; int lat;
    add_pair(8'h41, 8'h41, err);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_AA got=%b want=1", err); end
    tick();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rej_pulse got=%b want=0", cfg_err); end
    add_pair(8'h41, 8'h42, err);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_AB got=%b want=1", err); end
    add_pair(8'h40, 8'h42, err);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_range got=%b want=1", err); end
    valid = 1'b1; din = 8'h43;
    tick();
    valid = 1'b0;
    add_pair(8'h43, 8'h44, err);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_busy got=%b want=1", err); end
    tick();
    total++; if (pair_cnt !== 4'd1) begin bad++; $display("FAIL rej_cnt got=%0d want=1", pair_cnt); end
    run_char(8'h42, d, e, lat);
    total++; if (d !== 8'h42) begin bad++; $display("FAIL rej_B got=%h want=42", d); end
    run_char(8'h43, d, e, lat);
    total++; if (d !== 8'h43) begin bad++; $display("FAIL rej_C got=%h want=43", d); end
  endtask

  task automatic test_bad_char();
    valid = 1'b1; din = 8'h20;
    tick();
    din = 8'h59;
    tick();
    total++; if (done !== 1'b1 || dout !== 8'h20) begin bad++; $display("FAIL bad_done done=%b dout=%h want 1/20", done, dout); end
    total++; if (char_err !== 1'b1) begin bad++; $display("FAIL bad_char_err got=%b want=1", char_err); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad_k3_busy got=%b want=0", busy); end
    tick();
    valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bad_accept busy got=%b want=1", busy); end
    tick();
    total++; if (done !== 1'b1 || dout !== 8'h59 || char_err !== 1'b0) begin
      bad++; $display("FAIL bad_next done=%b dout=%h err=%b want 1/59/0", done, dout, char_err);
    end
    tick();
  endtask

  task automatic test_full();
    logic [7:0] d; logic e, err; int lat; int nerr;
    clear = 1'b1; tick(); clear = 1'b0;
    total++; if (pair_cnt !== 4'd0) begin bad++; $display("FAIL full_clr0 got=%0d want=0", pair_cnt); end
    nerr = 0;
    for (int i = 0; i < 13; i++) begin
      add_pair(8'(65 + 2 * i), 8'(66 + 2 * i), err);
      if (err) nerr++;
    end
    total++; if (nerr !== 0 || pair_cnt !== 4'd13) begin bad++; $display("FAIL full_load errs=%0d cnt=%0d want 0/13", nerr, pair_cnt); end
    add_pair(8'h41, 8'h43, err);
    total++; if (err !== 1'b1 || pair_cnt !== 4'd13) begin bad++; $display("FAIL full_14th err=%b cnt=%0d want 1/13", err, pair_cnt); end
    run_char(8'h43, d, e, lat);
    total++; if (d !== 8'h44) begin bad++; $display("FAIL full_C got=%h want=44", d); end
    clear = 1'b1; tick(); clear = 1'b0;
    total++; if (pair_cnt !== 4'd0) begin bad++; $display("FAIL full_clr got=%0d want=0", pair_cnt); end
    run_char(8'h41, d, e, lat);
    total++; if (d !== 8'h41) begin bad++; $display("FAIL full_clr_A got=%h want=41", d); end
    clear = 1'b1;
    add_pair(8'h41, 8'h42, err);
    clear = 1'b0;
    total++; if (err !== 1'b1 || pair_cnt !== 4'd0) begin bad++; $display("FAIL clr_pair err=%b cnt=%0d want 1/0", err, pair_cnt); end
    run_char(8'h41, d, e, lat);
    total++; if (d !== 8'h41) begin bad++; $display("FAIL clr_pair_A got=%h want=41", d); end
  endtask

  task automatic test_back_to_back();
    logic err;
    valid = 1'b1; din = 8'h41;
    add_pair(8'h41, 8'h42, err);
    valid = 1'b0;
    total++; if (err !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL vp_same err=%b busy=%b want 1/1", err, busy); end
    tick();
    total++; if (done !== 1'b1 || dout !== 8'h41) begin bad++; $display("FAIL vp_char done=%b dout=%h want 1/41", done, dout); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic e, err; int lat; int seen;
    add_pair(8'h41, 8'h5A, err);
    valid = 1'b1; din = 8'h41;
    tick();
    valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({busy, done} !== 2'b00 || dout !== 8'h00 || pair_cnt !== 4'd0) begin
      bad++; $display("FAIL rmid_state busy,done=%b dout=%h cnt=%0d want 00/00/0", {busy, done}, dout, pair_cnt);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_late_done got=%0d want=0", seen); end
    run_char(8'h41, d, e, lat);
    total++; if (d !== 8'h41 || lat !== 2) begin bad++; $display("FAIL rmid_A got=%h lat=%0d want=41 lat=2", d, lat); end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; pair_valid = 1'b0; valid = 1'b0;
    pair_a = 8'h00; pair_b = 8'h00; din = 8'h00;
    test_reset();
    test_identity();
    test_pair_az();
    test_reject();
    test_bad_char();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
